// File: rtl/lora_tx_sequencer.sv
// SX1278 LoRa transmit sequencer: one-time radio init, FIFO load, TX, TxDone poll with timeout.
// Drives an external SPI master with one 16-bit register access per request.
module lora_tx_sequencer #(
  parameter int unsigned MAX_LEN    = 64,
  parameter logic [7:0]  PA_CFG     = 8'h8F,
  parameter logic [7:0]  PA_DAC_VAL = 8'h84,
  parameter logic [7:0]  OCP_VAL    = 8'h2B,
  parameter int unsigned TIMEOUT    = 100000,
  localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  output logic             o_spi_req,
  output logic [7:0]       o_spi_addr,
  output logic [7:0]       o_spi_wdata,
  input  logic             i_spi_done,
  input  logic [7:0]       i_spi_rdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [1:0]       o_err_code,
  output logic [3:0]       o_state
);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(6);

  typedef enum logic [3:0] {
    S_INIT_VER = 4'd0, S_INIT = 4'd1, S_IDLE = 4'd2, S_SET_PTR = 4'd3,
    S_SET_LEN = 4'd4, S_FIFO_WR = 4'd5, S_TX = 4'd6, S_POLL = 4'd7,
    S_CLEAR = 4'd8, S_STBY = 4'd9, S_ERR = 4'd10
  } state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic [7:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [15:0]      init_entry;
  logic             tmo_hit;

  // Init table entries as {write bit | reg address, data}
  always_comb begin
    init_entry = 16'h0000;
    case (idx_q)
      3'd0:    init_entry = {8'h81, 8'h80};
      3'd1:    init_entry = {8'h81, 8'h81};
      3'd2:    init_entry = {8'h89, PA_CFG};
      3'd3:    init_entry = {8'hCD, PA_DAC_VAL};
      3'd4:    init_entry = {8'h8B, OCP_VAL};
      3'd5:    init_entry = {8'hA6, 8'h04};
      3'd6:    init_entry = {8'h8E, 8'h00};
      default: init_entry = 16'h0000;
    endcase
  end

  assign tmo_hit = (tmo_q >= TMO_W'(TIMEOUT));

  // Next-state and next-output logic; every state issues when req is low and advances on done
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
    code_d  = code_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_INIT_VER: begin
        if (!req_q) begin
          {req_d, addr_d, wdata_d} = {1'b1, 8'h42, 8'h00};
        end else if (i_spi_done) begin
          req_d = 1'b0;
          idx_d = '0;
          if (i_spi_rdata == 8'h12) begin
            state_d = S_INIT;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = 2'd1;
          end
        end
      end
      S_INIT: begin
        if (!req_q) begin
          {req_d, addr_d, wdata_d} = {1'b1, init_entry};
        end else if (i_spi_done) begin
          req_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_IDLE: begin
        if (i_start) begin
          if (i_len == '0 || i_len > LEN_W'(MAX_LEN)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = 2'd2;
          end else begin
            len_d   = i_len;
            cnt_d   = '0;
            state_d = S_SET_PTR;
          end
        end
      end
      S_SET_PTR: begin
        if (!req_q) begin
          {req_d, addr_d, wdata_d} = {1'b1, 8'h8D, 8'h00};
        end else if (i_spi_done) begin
          req_d   = 1'b0;
          state_d = S_SET_LEN;
        end
      end
      S_SET_LEN: begin
        if (!req_q) begin
          {req_d, addr_d, wdata_d} = {1'b1, 8'hA2, 8'(len_q)};
        end else if (i_spi_done) begin
          req_d   = 1'b0;
          state_d = S_FIFO_WR;
        end
      end
      S_FIFO_WR: begin
        // An accepted byte is launched straight into its FIFO write, so a held byte == req high
        if (!req_q) begin
          if (ready_q && i_byte_valid) begin
            {req_d, addr_d, wdata_d} = {1'b1, 8'h80, i_byte};
          end
        end else if (i_spi_done) begin
          req_d = 1'b0;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) state_d = S_TX;
        end
      end
      S_TX: begin
        tmo_d = '0;
        if (!req_q) begin
          {req_d, addr_d, wdata_d} = {1'b1, 8'h81, 8'h83};
        end else if (i_spi_done) begin
          req_d   = 1'b0;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        if (!tmo_hit) tmo_d = tmo_q + TMO_W'(1);
        if (!req_q) begin
          if (tmo_hit) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = 2'd3;
          end else begin
            {req_d, addr_d, wdata_d} = {1'b1, 8'h12, 8'h00};
          end
        end else if (i_spi_done) begin
          req_d = 1'b0;
          if (i_spi_rdata[3]) begin
            state_d = S_CLEAR;
          end else if (tmo_hit) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = 2'd3;
          end
        end
      end
      S_CLEAR: begin
        if (!req_q) begin
          {req_d, addr_d, wdata_d} = {1'b1, 8'h92, 8'hFF};
        end else if (i_spi_done) begin
          req_d   = 1'b0;
          state_d = S_STBY;
        end
      end
      S_STBY: begin
        if (!req_q) begin
          {req_d, addr_d, wdata_d} = {1'b1, 8'h81, 8'h81};
        end else if (i_spi_done) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        req_d = 1'b0;
        if (i_start) begin
          err_d   = 1'b0;
          code_d  = 2'd0;
          state_d = S_INIT_VER;
        end
      end
      default: state_d = S_INIT_VER;
    endcase

    ready_d = (state_d == S_FIFO_WR) && !req_d;
    busy_d  = (state_d != S_IDLE) && (state_d != S_ERR);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_INIT_VER;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_byte_ready = ready_q;
  assign o_spi_req    = req_q;
  assign o_spi_addr   = addr_q;
  assign o_spi_wdata  = wdata_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_err_code   = code_q;
  assign o_state      = state_q;

endmodule
